// File: rtl/mem_port.sv
// Memory port: one outstanding bus access at a time, with a sticky fault flag.
// Optional access timeout is enabled by defining MEM_PORT_TIMEOUT_EN.
module mem_port #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic        ior_d,
  input  logic        ir_wr,
  input  logic [31:0] pc,
  input  logic [31:0] alu_out,
  input  logic [31:0] wr_data,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        busy,
  output logic [31:0] ir,
  output logic [31:0] mdr,
  output logic [5:0]  op,
  output logic [5:0]  func,
  output logic        fault
);

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("mem_port: TIMEOUT must be in 1..255");
  end

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  state_e      state_q, state_d;
  logic [31:0] eff_addr;
  logic        cmd_any, cmd_valid, cmd_bad;
  logic        accept, complete, timeout_hit;
  logic        we_q, dst_ir_q, fault_q;
  logic [31:0] addr_q, wdata_q, ir_q, mdr_q;

  assign eff_addr  = ior_d ? alu_out : pc;
  assign cmd_any   = mem_rd | mem_wr;
  assign cmd_valid = (mem_rd ^ mem_wr) && (eff_addr[1:0] == 2'b00);
  assign cmd_bad   = cmd_any && !cmd_valid;
  assign accept    = (state_q == StIdle) && cmd_valid;
  assign complete  = (state_q == StAccess) && bus_ack;

`ifdef MEM_PORT_TIMEOUT_EN
  logic [7:0] cnt_q;

  // Held at zero while idle, so every access starts counting from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else if (state_q != StAccess) begin
      cnt_q <= 8'd0;
    end else if (!bus_ack) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  // Abort in the cycle the count would reach TIMEOUT: bus_req spans TIMEOUT cycles.
  assign timeout_hit = (state_q == StAccess) && !bus_ack && (cnt_q == 8'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (cmd_valid) state_d = StAccess;
      StAccess: if (bus_ack || timeout_hit) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    bus_req = 1'b0;
    bus_we  = 1'b0;
    busy    = 1'b0;
    unique case (state_q)
      StIdle: busy = cmd_valid;
      StAccess: begin
        bus_req = 1'b1;
        bus_we  = we_q;
        busy    = !bus_ack && !timeout_hit;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      we_q     <= 1'b0;
      dst_ir_q <= 1'b0;
      ir_q     <= 32'd0;
      mdr_q    <= 32'd0;
      fault_q  <= 1'b0;
    end else begin
      if (accept) begin
        addr_q   <= eff_addr;
        wdata_q  <= wr_data;
        we_q     <= mem_wr;
        dst_ir_q <= ir_wr;
      end
      if (complete && !we_q) begin
        if (dst_ir_q) ir_q <= bus_rdata;
        else          mdr_q <= bus_rdata;
      end
      if (((state_q == StIdle) && cmd_bad) || timeout_hit) begin
        fault_q <= 1'b1;
      end
    end
  end

  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign ir        = ir_q;
  assign mdr       = mdr_q;
  assign op        = ir_q[31:26];
  assign func      = ir_q[5:0];
  assign fault     = fault_q;

endmodule

// File: tb/tb_mem_port.sv
// Self-checking bench for mem_port: directed cases plus randomized accesses
// checked against a transaction-level model of ir/mdr/fault.
module tb_mem_port;

  logic        clk, rst_n;
  logic        mem_rd, mem_wr, ior_d, ir_wr;
  logic [31:0] pc, alu_out, wr_data;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_ack, busy;
  logic [31:0] ir, mdr;
  logic [5:0]  op, func;
  logic        fault;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] exp_ir, exp_mdr;
  logic        exp_fault;

  mem_port #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .mem_rd(mem_rd), .mem_wr(mem_wr), .ior_d(ior_d),
    .ir_wr(ir_wr), .pc(pc), .alu_out(alu_out), .wr_data(wr_data), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_ack(bus_ack), .busy(busy), .ir(ir), .mdr(mdr), .op(op), .func(func), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chk_regs();
    chk("ir", ir, exp_ir);
    chk("mdr", mdr, exp_mdr);
    chk("op", {26'd0, op}, {26'd0, exp_ir[31:26]});
    chk("func", {26'd0, func}, {26'd0, exp_ir[5:0]});
    chk("fault", {31'd0, fault}, {31'd0, exp_fault});
  endtask

  // One valid access; ack arrives in ACCESS cycle number dly (0 = immediate).
  task automatic do_access(input logic rd, input logic wr, input logic iord, input logic irwr,
                           input logic [31:0] pcv, input logic [31:0] aluv,
                           input logic [31:0] wd, input logic [31:0] rdata, input int dly);
    logic [31:0] addr;
    addr = iord ? aluv : pcv;
    @(negedge clk);
    mem_rd = rd; mem_wr = wr; ior_d = iord; ir_wr = irwr;
    pc = pcv; alu_out = aluv; wr_data = wd;
    #1 chk("busy_accept", {31'd0, busy}, 32'd1);
    for (int k = 0; k <= dly; k++) begin
      @(negedge clk);
      // Command inputs are scrambled while the access is in flight.
      mem_rd = 1'($urandom); mem_wr = 1'($urandom); ior_d = 1'($urandom);
      ir_wr = 1'($urandom); pc = $urandom; alu_out = $urandom; wr_data = $urandom;
      bus_ack = (k == dly);
      bus_rdata = (k == dly) ? rdata : $urandom;
      #1;
      chk("bus_req_access", {31'd0, bus_req}, 32'd1);
      chk("bus_addr", bus_addr, addr);
      chk("bus_we", {31'd0, bus_we}, {31'd0, wr});
      if (wr) chk("bus_wdata", bus_wdata, wd);
      chk("busy_access", {31'd0, busy}, (k == dly) ? 32'd0 : 32'd1);
    end
    @(negedge clk);
    mem_rd = 1'b0; mem_wr = 1'b0; bus_ack = 1'b0;
    if (rd) begin
      if (irwr) exp_ir = rdata;
      else      exp_mdr = rdata;
    end
    #1;
    chk("bus_req_done", {31'd0, bus_req}, 32'd0);
    chk("bus_we_done", {31'd0, bus_we}, 32'd0);
    chk_regs();
  endtask

  initial begin
    int hold;
    logic rd;
    rst_n = 1'b0; mem_rd = 0; mem_wr = 0; ior_d = 0; ir_wr = 0;
    pc = 0; alu_out = 0; wr_data = 0; bus_rdata = 0; bus_ack = 0;
    exp_ir = 0; exp_mdr = 0; exp_fault = 0;
    #12;
    chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst_bus_we", {31'd0, bus_we}, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk_regs();
    @(negedge clk);
    rst_n = 1'b1;

    // Fetch, ack in the second ACCESS cycle
    do_access(1'b1, 1'b0, 1'b0, 1'b1, 32'h4, 32'h0, 32'h0, 32'h8C220008, 1);
    chk("fetch_op", {26'd0, op}, 32'h23);
    chk("fetch_func", {26'd0, func}, 32'h08);
    // Store, immediate ack
    do_access(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h100, 32'hDEADBEEF, 32'h12345678, 0);

    // Ack while idle is ignored
    @(negedge clk);
    bus_ack = 1'b1; bus_rdata = 32'hA5A5A5A5;
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    chk("idle_ack_req", {31'd0, bus_req}, 32'd0);
    chk_regs();

    for (int i = 0; i < 40; i++) begin
      rd = 1'($urandom);
      do_access(rd, !rd, 1'($urandom), 1'($urandom), $urandom & 32'hFFFF_FFFC,
                $urandom & 32'hFFFF_FFFC, $urandom, $urandom, int'($urandom_range(0, 2)));
    end

`ifdef MEM_PORT_TIMEOUT_EN
    // Read with no ack: aborts after TIMEOUT cycles of bus_req
    @(negedge clk);
    mem_rd = 1'b1; ior_d = 1'b0; ir_wr = 1'b0; pc = 32'h40;
    #1 chk("to_busy_accept", {31'd0, busy}, 32'd1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      mem_rd = 1'b0;
      #1;
      chk("to_bus_req", {31'd0, bus_req}, 32'd1);
      chk("to_busy", {31'd0, busy}, (c == 3) ? 32'd0 : 32'd1);
    end
    @(negedge clk);
    exp_fault = 1'b1;
    #1;
    chk("to_bus_req_drop", {31'd0, bus_req}, 32'd0);
    chk_regs();
`else
    // Read with no ack: request held indefinitely
    @(negedge clk);
    mem_rd = 1'b1; ior_d = 1'b0; ir_wr = 1'b0; pc = 32'h40;
    hold = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      mem_rd = 1'b0;
      #1 if (bus_req && busy) hold++;
    end
    chk("noto_hold_cycles", hold, 300);
    @(negedge clk);
    bus_ack = 1'b1; bus_rdata = 32'h0BADF00D;
    @(negedge clk);
    bus_ack = 1'b0; exp_mdr = 32'h0BADF00D;
    #1;
    chk("noto_bus_req_drop", {31'd0, bus_req}, 32'd0);
    chk_regs();
`endif

    // Reset in the middle of an access
    @(negedge clk);
    mem_rd = 1'b1; ior_d = 1'b1; ir_wr = 1'b1; alu_out = 32'h200;
    @(negedge clk);
    mem_rd = 1'b0;
    #1 chk("mid_bus_req", {31'd0, bus_req}, 32'd1);
    #1 rst_n = 1'b0;
    exp_ir = 0; exp_mdr = 0; exp_fault = 0;
    #1;
    chk("mid_rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk_regs();
    @(negedge clk);
    rst_n = 1'b1; bus_ack = 1'b1; bus_rdata = 32'hFFFF0000;
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    chk("late_ack_req", {31'd0, bus_req}, 32'd0);
    chk_regs();

    do_access(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h300, 32'h0, 32'hCAFE0001, 0);

    // Misaligned read
    @(negedge clk);
    mem_rd = 1'b1; ior_d = 1'b1; alu_out = 32'h102;
    #1 chk("mis_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    mem_rd = 1'b0; exp_fault = 1'b1;
    #1 chk("mis_bus_req", {31'd0, bus_req}, 32'd0);
    chk_regs();

    // Read and write together
    @(negedge clk);
    mem_rd = 1'b1; mem_wr = 1'b1; ior_d = 1'b0; pc = 32'h8;
    #1 chk("conf_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    mem_rd = 1'b0; mem_wr = 1'b0;
    #1 chk("conf_bus_req", {31'd0, bus_req}, 32'd0);
    chk_regs();

    // Fault stays set across later good accesses
    do_access(1'b1, 1'b0, 1'b0, 1'b1, 32'hC, 32'h0, 32'h0, 32'h00221820, 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
